// File: rtl/slc3_bus_pkg.sv
// Shared types for the SimplifiedLC3 internal bus: driver indices and arbiter states.
// Index order matches the req/grant bit order used by the bus mux.
package slc3_bus_pkg;

  localparam int NUM_BUS_SRC = 4;

  typedef enum logic [1:0] {
    SRC_PC  = 2'd0,
    SRC_ALU = 2'd1,
    SRC_MDR = 2'd2,
    SRC_MAR = 2'd3
  } bus_src_t;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } arb_state_t;

  function automatic logic [NUM_BUS_SRC-1:0] src_onehot(input logic [1:0] idx);
    src_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching from last+1 upward, wrapping.
// No state, no latency; the previous winner gets the lowest priority.
module rr_pick
  import slc3_bus_pkg::*;
(
  input  logic [NUM_BUS_SRC-1:0] req,
  input  logic [1:0]             last,
  output logic                   valid,
  output logic [1:0]             idx
);

  logic [1:0] cand;

  // Walk from the lowest-priority offset to the highest so the last hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    cand  = last;
    for (int i = NUM_BUS_SRC; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the 16-bit internal bus; drives one-hot registered Gate* selects.
// Request to gate 1 cycle; tenure bounded by MAX_HOLD under contention; TURN_CYCLES dead cycles between owners.
module bus_arbiter
  import slc3_bus_pkg::*;
#(
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_BUS_SRC-1:0] req,
  output logic                   GatePC,
  output logic                   GateALU,
  output logic                   GateMDR,
  output logic                   GateMAR,
  output logic [NUM_BUS_SRC-1:0] grant,
  output logic [1:0]             owner,
  output logic                   bus_busy
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

  arb_state_t state;
  logic [7:0] hold_cnt;
  logic [1:0] turn_cnt;
  logic       pick_vld;
  logic [1:0] pick_idx;
  logic       others_waiting;
  logic       rel_now;
  logic       arb_now;

  // owner doubles as the round-robin pointer: it is only rewritten on a grant.
  rr_pick u_pick (
    .req   (req),
    .last  (owner),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign others_waiting = |(req & ~src_onehot(owner));
  assign rel_now        = !req[owner] || ((hold_cnt == HOLD_LAST) && others_waiting);

  always_comb begin
    arb_now = 1'b0;
    case (state)
      IDLE:    arb_now = 1'b1;
      OWN:     arb_now = rel_now && (TURN_CYCLES == 0);
      TURN:    arb_now = (turn_cnt == TURN_LAST);
      default: arb_now = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= 2'd3;
      hold_cnt <= '0;
      turn_cnt <= '0;
      bus_busy <= 1'b0;
    end else if (arb_now) begin
      if (pick_vld) begin
        state    <= OWN;
        grant    <= src_onehot(pick_idx);
        owner    <= pick_idx;
        hold_cnt <= '0;
        bus_busy <= 1'b1;
      end else begin
        state    <= IDLE;
        grant    <= '0;
        bus_busy <= 1'b0;
      end
    end else begin
      case (state)
        OWN: begin
          if (rel_now) begin
            state    <= TURN;
            grant    <= '0;
            bus_busy <= 1'b0;
            turn_cnt <= '0;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        TURN:    turn_cnt <= turn_cnt + 2'd1;
        default: state <= IDLE;
      endcase
    end
  end

  assign GatePC  = grant[SRC_PC];
  assign GateALU = grant[SRC_ALU];
  assign GateMDR = grant[SRC_MDR];
  assign GateMAR = grant[SRC_MAR];

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: three instances with different hold/turnaround settings.
module tb_bus_arbiter;

  typedef struct packed {
    logic [1:0] dut;
    logic [3:0] gnt;
    logic [1:0] own;
  } exp_t;

  logic       Clk = 1'b0;
  logic       rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic [3:0] req_a = '0, req_b = '0, req_c = '0;

  logic       pc_a, alu_a, mdr_a, mar_a, busy_a;
  logic       pc_b, alu_b, mdr_b, mar_b, busy_b;
  logic       pc_c, alu_c, mdr_c, mar_c, busy_c;
  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] own_a, own_b, own_c;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] mdl_owner = 2'd3;

  // A: MAX_HOLD=2, TURN=1   B: MAX_HOLD=3, TURN=0   C: MAX_HOLD=8, TURN=1
  logic [3:0] tbl_a [14] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4,
                             4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
  logic [3:0] tbl_b [7]  = '{4'h2, 4'h2, 4'h2, 4'h8, 4'h8, 4'h8, 4'h2};

  always #5 Clk = ~Clk;

  bus_arbiter #(.MAX_HOLD(2), .TURN_CYCLES(1)) u_a (
    .Clk(Clk), .Reset(rst_a), .req(req_a),
    .GatePC(pc_a), .GateALU(alu_a), .GateMDR(mdr_a), .GateMAR(mar_a),
    .grant(gnt_a), .owner(own_a), .bus_busy(busy_a));

  bus_arbiter #(.MAX_HOLD(3), .TURN_CYCLES(0)) u_b (
    .Clk(Clk), .Reset(rst_b), .req(req_b),
    .GatePC(pc_b), .GateALU(alu_b), .GateMDR(mdr_b), .GateMAR(mar_b),
    .grant(gnt_b), .owner(own_b), .bus_busy(busy_b));

  bus_arbiter #(.MAX_HOLD(8), .TURN_CYCLES(1)) u_c (
    .Clk(Clk), .Reset(rst_c), .req(req_c),
    .GatePC(pc_c), .GateALU(alu_c), .GateMDR(mdr_c), .GateMAR(mar_c),
    .grant(gnt_c), .owner(own_c), .bus_busy(busy_c));

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    idx_of = 2'd0;
    for (int i = 0; i < 4; i++)
      if (g[i]) idx_of = 2'(i);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, want);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input int d, input logic rst, input logic [3:0] r, input logic [3:0] g);
    exp_t e;
    @(negedge Clk);
    case (d)
      0:       begin rst_a = rst; req_a = r; end
      1:       begin rst_b = rst; req_b = r; end
      default: begin rst_c = rst; req_c = r; end
    endcase
    if (!rst) mdl_owner = 2'd3;
    else if (g != 4'h0) mdl_owner = idx_of(g);
    e.dut = 2'(d);
    e.gnt = g;
    e.own = mdl_owner;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [3:0] g, gt;
    logic [1:0] o;
    logic       b;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        case (e.dut)
          2'd0:    begin g = gnt_a; gt = {mar_a, mdr_a, alu_a, pc_a}; o = own_a; b = busy_a; end
          2'd1:    begin g = gnt_b; gt = {mar_b, mdr_b, alu_b, pc_b}; o = own_b; b = busy_b; end
          default: begin g = gnt_c; gt = {mar_c, mdr_c, alu_c, pc_c}; o = own_c; b = busy_c; end
        endcase
        check("grant", g, e.gnt);
        check("gates", gt, e.gnt);
        check("owner", {2'b00, o}, {2'b00, e.own});
        check("bus_busy", {3'b000, b}, {3'b000, |e.gnt});
      end
    end
  end

  initial begin : driver
    int waited;

    // A: reset priority, full rotation with 2-cycle tenures and one dead cycle.
    step(0, 1'b0, 4'h0, 4'h0);
    step(0, 1'b0, 4'hF, 4'h0);
    foreach (tbl_a[i]) step(0, 1'b1, 4'hF, tbl_a[i]);

    // B: zero turnaround hand-off ALU <-> MAR, then reset mid-tenure.
    step(1, 1'b0, 4'h0, 4'h0);
    foreach (tbl_b[i]) step(1, 1'b1, 4'hA, tbl_b[i]);
    step(1, 1'b1, 4'h0, 4'h0);
    step(1, 1'b1, 4'h2, 4'h2);
    step(1, 1'b1, 4'h2, 4'h2);
    step(1, 1'b0, 4'h2, 4'h0);
    step(1, 1'b1, 4'h2, 4'h2);
    step(1, 1'b1, 4'h0, 4'h0);

    // C: single requester held 20 cycles, no preemption.
    step(2, 1'b0, 4'h0, 4'h0);
    repeat (20) step(2, 1'b1, 4'h4, 4'h4);
    step(2, 1'b1, 4'h0, 4'h0);
    step(2, 1'b1, 4'h0, 4'h0);

    // C: PC wins over MDR (pointer at MDR), releases early, MDR follows one dead cycle later.
    step(2, 1'b1, 4'h5, 4'h1);
    step(2, 1'b1, 4'h5, 4'h1);
    step(2, 1'b1, 4'h4, 4'h0);
    step(2, 1'b1, 4'h4, 4'h4);
    step(2, 1'b1, 4'h4, 4'h4);
    step(2, 1'b1, 4'h0, 4'h0);
    step(2, 1'b1, 4'h0, 4'h0);

    // C: one-cycle PC pulse during a MAR tenure is never granted.
    step(2, 1'b1, 4'h8, 4'h8);
    step(2, 1'b1, 4'h8, 4'h8);
    step(2, 1'b1, 4'h9, 4'h8);
    repeat (4) step(2, 1'b1, 4'h8, 4'h8);
    step(2, 1'b1, 4'h0, 4'h0);
    step(2, 1'b1, 4'h0, 4'h0);

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge Clk);
      waited++;
    end
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Sequential arbiter sharing the SimplifiedLC3 16-bit internal bus between its four drivers (PC, ALU, MDR, MAR). It sits directly ahead of the bus mux and drives the four Gate* selects. It guarantees at most one gate is ever high, rotates ownership round-robin, bounds each tenure, and optionally inserts dead cycles between owners.

## Interface
- MAX_HOLD, 8: maximum cycles an owner keeps the bus while another requester is waiting; legal range 1..255.
- TURN_CYCLES, 1: all-gates-off cycles between consecutive owners; legal range 0..3.

- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- req  in  4  bus requests, index 0=PC, 1=ALU, 2=MDR, 3=MAR; level-sensitive, held for the whole transfer.
- GatePC / GateALU / GateMDR / GateMAR  out  1 each  registered gate selects to the bus mux.
- grant  out  4  same one-hot vector as the gates, indexed like req.
- owner  out  2  index of the current/last owner.
- bus_busy  out  1  high while in OWN.

## Operation
- States: IDLE, OWN, TURN.
- IDLE: all gates 0. If any req bit is set, pick a winner by round-robin starting at (last_owner+1) mod 4. Next state is OWN, with the winner's gate set, owner=winner, and hold_cnt=0. With no requests, stay in IDLE.
- OWN: the owner's gate stays high and hold_cnt increments each cycle, saturating at MAX_HOLD-1.
  - Release when req[owner]=0.
  - Also release when hold_cnt==MAX_HOLD-1 and any other req bit is set (preemption).
  - With no other requester, the owner keeps the bus indefinitely.
- On release:
  - If TURN_CYCLES>0: go to TURN, all gates 0, turn_cnt=0.
  - If TURN_CYCLES=0: arbitrate immediately with the IDLE rule, excluding nothing. The new gate replaces the old one on the same edge; if no request is pending, go to IDLE.
- TURN: turn_cnt counts up. On the cycle with turn_cnt==TURN_CYCLES-1, arbitrate with the IDLE rule and enter OWN or IDLE.
- A preempted owner that still requests re-enters arbitration normally. Round-robin gives it lowest priority.
- last_owner is updated on every grant.
- Reset (Reset=0 at an edge, any state, mid-tenure included): state IDLE, all gates/grant 0, bus_busy 0, owner 3, last_owner 3 (PC wins first), counters 0.
- Invariant: grant is always 0 or one-hot; the gates equal grant bitwise.

## Timing
- Request to gate: 1 cycle. A req first sampled high at edge k in IDLE gives a gate high after edge k.
- Release to next gate:
  - TURN_CYCLES=0: the new gate is visible after the same edge that drops the old one.
  - TURN_CYCLES=N: exactly N all-zero cycles between owners.
- Req dropped by the owner: seen at edge k, gate low after edge k. The owner never loses the gate before it drops req, except through preemption.
- Preemption: with contention, a tenure lasts exactly MAX_HOLD cycles.
- A req raised and dropped while another owner holds the bus is never granted.
- Simultaneous requests: one winner per arbitration, order strictly round-robin.

## Structure
- Shared package slc3_bus_pkg holds:
  - bus_src_t enum {SRC_PC=0, SRC_ALU=1, SRC_MDR=2, SRC_MAR=3};
  - arb_state_t {IDLE, OWN, TURN};
  - NUM_BUS_SRC=4.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req[3:0] and last[1:0]; outputs are valid and idx[1:0]. It is reused for every arbitration point.
- All outputs come from registers; no combinational path from req to the gates.

## Test plan
- Reset priority: after reset, req=4'b1111 constant, MAX_HOLD=2, TURN_CYCLES=1 → tenures PC, ALU, MDR, MAR, PC, each 2 cycles with 1 zero cycle between; grant is never multi-hot.
- Single requester: req=4'b0100 for 20 cycles → GateMDR high for 20 cycles starting 1 cycle after req; no preemption; bus_busy high throughout. Drop req → gate 0 the next cycle; IDLE.
- Zero turnaround: TURN_CYCLES=0, req ALU and MAR both held, MAX_HOLD=3 → GateALU for 3 cycles, then GateMAR for 3 cycles on the adjacent edge with no gap and no overlap.
- Early release: PC owns, MDR waiting, PC drops req after 2 cycles (MAX_HOLD=8) → PC gate lasts 2 cycles, then TURN_CYCLES zero cycles, then GateMDR.
- Reset mid-tenure: GateALU high, Reset=0 for one edge → all gates 0 and owner=3 after that edge. Reset released with req=4'b0010 → GateALU again after 1 cycle.
- Transient request: MAR owns, req[0] pulses for 1 cycle mid-tenure → PC is never granted; MAR keeps the bus.
